// File: rtl/note_envelope_pkg.sv
// Shared note-packet definitions for the SPI receiver, envelope shapers and tone generators.
package note_envelope_pkg;

    localparam int unsigned PACKET_SIZE = 24;
    localparam int unsigned TUNE_W      = 16;
    localparam int unsigned VOL_W       = 8;
    localparam int unsigned TUNE_MSB    = 23;
    localparam int unsigned TUNE_LSB    = 8;
    localparam int unsigned VOL_MSB     = 7;
    localparam int unsigned VOL_LSB     = 0;

    typedef struct packed {
        logic [TUNE_W-1:0] tune_word;
        logic [VOL_W-1:0]  volume;
    } packetType;

    typedef enum logic [2:0] {
        IDLE,
        ATTACK,
        SUSTAIN,
        RELEASE,
        RETRIG
    } envState;

    // Rising ramp: add in 9 bits, then clamp at the target so 8 bits never wrap.
    function automatic logic [VOL_W-1:0] vol_rise(input logic [VOL_W-1:0] cur,
                                                  input logic [VOL_W-1:0] tgt,
                                                  input logic [VOL_W-1:0] inc);
        logic [VOL_W:0] sum;
        sum = {1'b0, cur} + {1'b0, inc};
        return (sum > {1'b0, tgt}) ? tgt : sum[VOL_W-1:0];
    endfunction

    // Falling ramp toward flr without undershoot; caller guarantees cur >= flr.
    function automatic logic [VOL_W-1:0] vol_fall(input logic [VOL_W-1:0] cur,
                                                  input logic [VOL_W-1:0] flr,
                                                  input logic [VOL_W-1:0] dec);
        return ((cur - flr) > dec) ? (cur - dec) : flr;
    endfunction

endpackage

// File: rtl/note_envelope_prescaler.sv
// Tick prescaler: counts amplitude-update strobes and flags every DIV-th one as an envelope step.
module env_prescaler #(
    parameter int unsigned DIV = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic step_c
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             last_c;

    always_comb begin
        last_c = (cnt_q == LAST);
        cnt_d  = cnt_q;
        if (tick) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign step_c = tick & last_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/note_envelope.sv
// Per-track attack/sustain/release volume shaper that holds the tune word through release.
// Define NOTE_ENVELOPE_EXP_RELEASE_EN for exponential-like decay in RELEASE and RETRIG.
module note_envelope
    import note_envelope_pkg::*;
#(
    parameter logic [7:0]  ATTACK_STEP  = 8'd4,
    parameter logic [7:0]  RELEASE_STEP = 8'd1,
    parameter int unsigned ENV_DIV      = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [PACKET_SIZE-1:0] noteIn,
    output logic [PACKET_SIZE-1:0] noteOut,
    output logic                   active
);

    envState           state_q, state_d;
    logic [VOL_W-1:0]  vol_q, vol_d;
    logic [TUNE_W-1:0] held_q, held_d;
    logic [TUNE_W-1:0] pend_q, pend_d;
    logic              active_q, active_d;

    logic              step_c;
    logic [TUNE_W-1:0] in_tune_c;
    logic [VOL_W-1:0]  in_vol_c;
    logic              note_on_c;
    logic [VOL_W-1:0]  rel_dec_c;
    logic [VOL_W-1:0]  rise_c;
    logic [VOL_W-1:0]  fall_c;
    logic              go_down_c;

    env_prescaler #(
        .DIV (ENV_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (reset),
        .tick   (tick),
        .step_c (step_c)
    );

    assign in_tune_c = noteIn[TUNE_MSB:TUNE_LSB];
    assign in_vol_c  = noteIn[VOL_MSB:VOL_LSB];
    assign note_on_c = (in_tune_c != '0) && (in_vol_c != '0);

`ifdef NOTE_ENVELOPE_EXP_RELEASE_EN
    logic [VOL_W-1:0] shr_c;
    assign shr_c     = vol_q >> 3;
    assign rel_dec_c = (shr_c > RELEASE_STEP) ? shr_c : RELEASE_STEP;
`else
    assign rel_dec_c = RELEASE_STEP;
`endif

    assign rise_c = vol_rise(vol_q, in_vol_c, ATTACK_STEP);
    assign fall_c = vol_fall(vol_q, '0, rel_dec_c);

    // Envelope next state; a step that enters RELEASE/RETRIG also applies the first decrement.
    always_comb begin
        state_d   = state_q;
        vol_d     = vol_q;
        held_d    = held_q;
        pend_d    = pend_q;
        go_down_c = 1'b0;

        if ((state_q == RETRIG) && (in_tune_c != '0)) begin
            pend_d = in_tune_c;
        end

        if (step_c) begin
            case (state_q)
                IDLE: begin
                    if (note_on_c) begin
                        held_d  = in_tune_c;
                        vol_d   = rise_c;
                        state_d = (rise_c == in_vol_c) ? SUSTAIN : ATTACK;
                    end
                end
                ATTACK, SUSTAIN: begin
                    if (!note_on_c) begin
                        state_d   = RELEASE;
                        go_down_c = 1'b1;
                    end else if (in_tune_c != held_q) begin
                        state_d   = RETRIG;
                        pend_d    = in_tune_c;
                        go_down_c = 1'b1;
                    end else if (state_q == ATTACK) begin
                        vol_d = rise_c;
                        if (rise_c == in_vol_c) begin
                            state_d = SUSTAIN;
                        end
                    end else if (vol_q < in_vol_c) begin
                        vol_d = rise_c;
                    end else begin
                        vol_d = vol_fall(vol_q, in_vol_c, RELEASE_STEP);
                    end
                end
                RELEASE: begin
                    if (note_on_c && (in_tune_c == held_q)) begin
                        vol_d   = rise_c;
                        state_d = (rise_c == in_vol_c) ? SUSTAIN : ATTACK;
                    end else if (note_on_c) begin
                        state_d   = RETRIG;
                        pend_d    = in_tune_c;
                        go_down_c = 1'b1;
                    end else begin
                        go_down_c = 1'b1;
                    end
                end
                RETRIG: begin
                    go_down_c = 1'b1;
                end
                default: begin
                    state_d = IDLE;
                    vol_d   = '0;
                    held_d  = '0;
                end
            endcase

            // Reaching silence either hands over to the pending note or goes idle.
            if (go_down_c) begin
                vol_d = fall_c;
                if (fall_c == '0) begin
                    if ((state_d == RETRIG) && note_on_c) begin
                        held_d  = pend_d;
                        state_d = ATTACK;
                    end else begin
                        held_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
        end

        active_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            vol_q    <= '0;
            held_q   <= '0;
            pend_q   <= '0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            vol_q    <= vol_d;
            held_q   <= held_d;
            pend_q   <= pend_d;
            active_q <= active_d;
        end
    end

    assign noteOut = {held_q, vol_q};
    assign active  = active_q;

    a_attack_step_nonzero: assert property (@(posedge clk) disable iff (!reset) ATTACK_STEP != 8'd0)
        else $error("note_envelope: ATTACK_STEP must be nonzero");

    a_env_div_range: assert property (@(posedge clk) disable iff (!reset)
                                      (ENV_DIV >= 2) && (ENV_DIV <= 256))
        else $error("note_envelope: ENV_DIV must be within 2..256");

endmodule

// File: doc/note_envelope.md
Name: note_envelope

Overview:
- Per-track volume envelope shaper between the SPI receiver and the tone generators.
- Takes the 24-bit note packet {tuneWord[15:0], volume[7:0]} and emits a packet of the same format:
  - the volume ramps up on note start (attack) and ramps down on note stop or note change (release);
  - the tuneWord is held through the release so notes decay instead of clicking.
- Instantiated as an array, one instance per track, clocked at 40 MHz and stepped by the 156.25 kHz amplitude-update strobe.

Parameters:
- ATTACK_STEP, 8'd4, volume increment per envelope step while rising.
- RELEASE_STEP, 8'd1, volume decrement per envelope step while falling.
- ENV_DIV, 64, tick strobes per envelope step (2..256).

Ports:
- clk  in  1  system clock, 40 MHz.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- tick  in  1  one-cycle amplitude-update strobe (wgEn), every 256 clk.
- noteIn  in  24  packet from SPI: [23:8] tuneWord, [7:0] target volume.
- noteOut  out  24  shaped packet to toneGenerator: [23:8] held tuneWord, [7:0] current volume.
- active  out  1  high whenever state != IDLE.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, curVol=0, heldTune=0, pendTune=0, prescaler=0, noteOut=0, active=0.
- Prescaler:
  - counts tick pulses 0..ENV_DIV-1 and wraps;
  - step = tick & (prescaler==ENV_DIV-1);
  - state and volume change only on step cycles;
  - free-running, never reset by note events.
- "Note on" means noteIn tuneWord!=0 and volume!=0; otherwise the input is "note off".
- States and transitions, evaluated on step:
  - IDLE: curVol=0. Note on -> heldTune=tuneWord, go ATTACK.
  - ATTACK: curVol=min(curVol+ATTACK_STEP, target), using 9-bit sum then saturate.
    - Reached target -> SUSTAIN.
    - Note off -> RELEASE.
    - Different nonzero tuneWord -> RETRIG.
  - SUSTAIN: follow target; move up by ATTACK_STEP or down by RELEASE_STEP, clamped at target.
    - Note off -> RELEASE.
    - Different nonzero tuneWord -> RETRIG.
  - RELEASE: curVol=max(curVol-RELEASE_STEP, 0), no underflow wrap.
    - Reached 0 -> IDLE, heldTune=0.
    - Note on with tuneWord==heldTune -> ATTACK from current curVol.
    - Note on with a different tuneWord -> RETRIG.
  - RETRIG: pendTune = latest nonzero tuneWord, overwritten by each newer one. Ramp curVol down as in RELEASE.
    - At 0: heldTune=pendTune and go ATTACK if note is still on, else IDLE.
- A target volume change alone never causes a retrigger.
- Simultaneous note change and step: the noteIn sampled on the step cycle decides.
- Between steps, noteIn changes have no effect except pendTune capture.
- Outputs are registered:
  - noteOut={heldTune, curVol} updates on the clock edge ending a step cycle;
  - toneGenerator samples currentVol on that same edge, so the new volume reaches it on the next tick (one-tick latency by design).
- Output in IDLE is exactly 24'h0.
- ATTACK_STEP=0 is illegal; assertion in simulation.

Optional Feature:
- NOTE_ENVELOPE_EXP_RELEASE_EN
- Defined: the decrement in RELEASE and RETRIG is max(curVol>>3, RELEASE_STEP), giving an exponential-like decay that still always reaches 0.
- Undefined: linear decrement of RELEASE_STEP. SUSTAIN downward tracking is linear in both builds.

Decomposition:
- Shared package: PACKET_SIZE, packetType, envState enum {IDLE, ATTACK, SUSTAIN, RELEASE, RETRIG}, tuneWord/volume field slice constants.
- The package is also used by the SPI receiver and toneGenerator.
- One sub-module: env_prescaler (tick counter plus step strobe), reusable by future modulation blocks.

Test Plan:
- Reset mid-attack: drive reset=0 asynchronously -> noteOut=0 and active=0 immediately, with no clk edge required.
- Note on {16'h0400, 8'd200} from IDLE, defaults -> noteOut volume 4, 8, ... 196, then 200 on the 50th step; state SUSTAIN; tuneWord output 16'h0400 from the first step.
- In SUSTAIN at 200, send {16'h0000, 8'd0} -> volume falls by 1 per step; tuneWord stays 16'h0400 until volume hits 0; then noteOut=0 and active=0 (200 steps = 12800 ticks).
- In SUSTAIN at 200, change tuneWord to 16'h0500, then 16'h0600 during RETRIG -> ramp to 0 with tune 16'h0400, then attack with 16'h0600 (16'h0500 never output).
- Target change 200 -> 100 in SUSTAIN -> step down by 1 to exactly 100, no retrigger; then 100 -> 255 -> step up by 4, saturating at 255 with no wrap.
- With NOTE_ENVELOPE_EXP_RELEASE_EN, release from 200 -> 200, 175, 154, 135, ... down to exactly 0; without it -> 199, 198, ... 0.
